// File: rtl/ex_div_if.sv
// Divider request/response bundle between the EX stage and the divide unit.
interface ex_div_if #(parameter int DATA_W = 32);
  logic                  div_start;
  logic                  signed_div;
  logic [DATA_W-1:0]     dividend;
  logic [DATA_W-1:0]     divisor;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stallreq_for_ex;

  modport master (
    output div_start, signed_div, dividend, divisor, annul,
    input  result, ready, stallreq_for_ex
  );

  modport slave (
    input  div_start, signed_div, dividend, divisor, annul,
    output result, ready, stallreq_for_ex
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider; stalls EX while a DIV/DIVU is in flight.
module ex_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);
  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_dvs;
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_sgn_a, w_sgn_b;
  logic [DATA_W-1:0]     w_abs_a, w_abs_b;
  logic [DATA_W:0]       w_trial, w_diff;
  logic                  w_qbit;
  logic [DATA_W-1:0]     w_rem_nx, w_quo_nx;
  logic                  w_last;

  assign w_accept = (r_state == S_IDLE) && bus.div_start && !bus.annul;
  assign w_sgn_a  = bus.signed_div & bus.dividend[MSB];
  assign w_sgn_b  = bus.signed_div & bus.divisor[MSB];
  assign w_abs_a  = w_sgn_a ? -bus.dividend : bus.dividend;
  assign w_abs_b  = w_sgn_b ? -bus.divisor  : bus.divisor;

  // r_quo doubles as the dividend shift register: its MSB feeds the remainder,
  // quotient bits enter at the LSB. Borrow out of the wide subtract = restore.
  assign w_trial  = {r_rem, r_quo[MSB]};
  assign w_diff   = w_trial - {1'b0, r_dvs};
  assign w_qbit   = ~w_diff[DATA_W];
  assign w_rem_nx = w_qbit ? w_diff[MSB:0] : w_trial[MSB:0];
  assign w_quo_nx = {r_quo[MSB-1:0], w_qbit};
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  assign bus.stallreq_for_ex = !rst && (w_accept ||
    (((r_state == S_BY_ZERO) || (r_state == S_ON)) && !bus.annul));
  assign bus.result = r_result;
  assign bus.ready  = r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.divisor == '0) begin
              r_state <= S_BY_ZERO;
            end else begin
              r_state  <= S_ON;
              r_cnt    <= '0;
              r_rem    <= '0;
              r_quo    <= w_abs_a;
              r_dvs    <= w_abs_b;
              r_sign_q <= w_sgn_a ^ w_sgn_b;
              r_sign_r <= w_sgn_a;
            end
          end
        end
        S_BY_ZERO: begin
          if (bus.annul) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_END;
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (bus.annul) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state  <= S_END;
              r_ready  <= 1'b1;
              r_result <= {(r_sign_r ? -w_rem_nx : w_rem_nx),
                           (r_sign_q ? -w_quo_nx : w_quo_nx)};
            end
          end
        end
        S_END:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed-vector bench for ex_div_unit: results, latency, stall window, annul and reset.
module tb_ex_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  ex_div_if #(.DATA_W(32)) bus ();
  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge ending the ready cycle.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic stall_ok);
    bus.signed_div = sg;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_start  = 1'b1;
    lat      = -1;
    stall_ok = 1'b1;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat = c;
        if (bus.stallreq_for_ex) stall_ok = 1'b0;
      end else if (!bus.stallreq_for_ex) begin
        stall_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        bus.div_start  = 1'b0;
        bus.dividend   = $urandom;
        bus.divisor    = $urandom;
        bus.signed_div = ~sg;
      end
    end
  endtask

  initial begin
    int          lat;
    logic        sok;
    logic        saw;
    logic [63:0] prior;
    int          t0;

    tv[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
    tv[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
    tv[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    tv[3] = '{1'b0, 32'h12345678,   32'd0,        64'h00000000_00000000, 2};
    tv[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
    tv[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
    tv[6] = '{1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 33};
    tv[7] = '{1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 33};
    tv[8] = '{1'b1, 32'd0,          32'd0,        64'h00000000_00000000, 2};
    tv[9] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 33};

    rst = 1'b1;
    bus.div_start  = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd10;
    bus.divisor    = 32'd2;
    bus.annul      = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_stall", bus.stallreq_for_ex, 0);
    bus.div_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      do_div(tv[i].sg, tv[i].a, tv[i].b, lat, sok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_result", i), bus.result, tv[i].res);
      chk($sformatf("v%0d_stall_window", i), sok, 1);
      @(negedge clk);
      chk($sformatf("v%0d_ready_pulse", i), bus.ready, 0);
      @(posedge clk); #1;
    end

    // Annul mid-divide in cycle 10
    prior = tv[9].res;
    bus.signed_div = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    bus.div_start = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c == 10) bus.annul = 1'b1;
      @(negedge clk);
      if (bus.ready) saw = 1'b1;
      if (c == 10) chk("annul_stall_c10", bus.stallreq_for_ex, 0);
      if (c == 11) chk("annul_idle_c11", bus.stallreq_for_ex, 0);
      @(posedge clk); #1;
      if (c == 0) bus.div_start = 1'b0;
      if (c == 10) bus.annul = 1'b0;
    end
    chk("annul_no_ready", saw, 0);
    chk("annul_result_kept", bus.result, prior);
    do_div(1'b0, 32'd9, 32'd3, lat, sok);
    chk("post_annul_latency", 64'(lat), 33);
    chk("post_annul_result", bus.result, 64'h00000000_00000003);

    // Annul in BY_ZERO
    bus.signed_div = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd0;
    bus.div_start = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) bus.annul = 1'b1;
      @(negedge clk);
      if (bus.ready) saw = 1'b1;
      if (c == 1) chk("annul_byzero_stall", bus.stallreq_for_ex, 0);
      @(posedge clk); #1;
      if (c == 0) bus.div_start = 1'b0;
      if (c == 1) bus.annul = 1'b0;
    end
    chk("annul_byzero_no_ready", saw, 0);

    // Annul while idle blocks accept
    bus.div_start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    sok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.stallreq_for_ex) sok = 1'b0;
      @(posedge clk); #1;
    end
    bus.div_start = 1'b0; bus.annul = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (bus.ready) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("annul_idle_no_stall", sok, 1);
    chk("annul_idle_no_accept", saw, 0);

    // Annul during END is ignored
    bus.signed_div = 1'b0; bus.dividend = 32'd20; bus.divisor = 32'd4;
    bus.div_start = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (c == 33) bus.annul = 1'b1;
      @(negedge clk);
      if (c == 33) chk("annul_end_ready", bus.ready, 1);
      @(posedge clk); #1;
      if (c == 0) bus.div_start = 1'b0;
      if (c == 33) bus.annul = 1'b0;
    end
    chk("annul_end_result", bus.result, 64'h00000000_00000005);

    // Reset in cycle 20 of a divide
    bus.signed_div = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    bus.div_start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) bus.div_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stall_in_rst", bus.stallreq_for_ex, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.ready, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_stall", bus.stallreq_for_ex, 0);
    @(posedge clk); #1;
    t0 = cyc;
    do_div(1'b0, 32'd1000, 32'd3, lat, sok);
    chk("b2b_a_result", bus.result, 64'h00000001_0000014D);
    do_div(1'b0, 32'hFFFFFFFF, 32'h00010000, lat, sok);
    chk("b2b_b_result", bus.result, 64'h0000FFFF_0000FFFF);
    chk("b2b_cycles", 64'(cyc - t0), 68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
